// File: rtl/scc_isa_pkg.sv
// scc_isa_pkg: shared SCC ISA opcodes, condition codes, flag indices and decode state type
package scc_isa_pkg;
  localparam logic [6:0] OP_ADD   = 7'h00;
  localparam logic [6:0] OP_SUB   = 7'h01;
  localparam logic [6:0] OP_AND   = 7'h02;
  localparam logic [6:0] OP_OR    = 7'h03;
  localparam logic [6:0] OP_XOR   = 7'h04;
  localparam logic [6:0] OP_ADDI  = 7'h05;
  localparam logic [6:0] OP_SHL   = 7'h06;
  localparam logic [6:0] OP_SHR   = 7'h07;
  localparam logic [6:0] OP_LD    = 7'h20;
  localparam logic [6:0] OP_ST    = 7'h21;
  localparam logic [6:0] OP_B     = 7'b1100000;
  localparam logic [6:0] OP_BCOND = 7'b1100001;
  localparam logic [6:0] OP_BR    = 7'b1100010;
  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  typedef enum logic [1:0] {ST_RUN, ST_HOLD, ST_SQUASH} id_state_e;
  function automatic logic is_legal_op(input logic [6:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI, OP_SHL, OP_SHR,
                      OP_LD, OP_ST, OP_B, OP_BCOND, OP_BR};
  endfunction
endpackage

// File: rtl/instr_decode_if.sv
// instr_decode_if: fetch/flags inputs and decoded-field outputs of the ID stage
// ID_ILLEGAL_TRAP_EN adds illegal_op
interface instr_decode_if;
  logic [31:0] instruction_in;
  logic [31:0] pc_in;
  logic        valid_in;
  logic        stall_in;
  logic [3:0]  flags_in;
  logic [6:0]  opcode_out;
  logic [2:0]  rd_out;
  logic [2:0]  rs1_out;
  logic [2:0]  rs2_out;
  logic [31:0] imm_out;
  logic        valid_out;
  logic        ready_out;
  logic        cond_br_taken;
  logic [31:0] cond_br_target;
`ifdef ID_ILLEGAL_TRAP_EN
  logic        illegal_op;
`endif
  modport master (
    output instruction_in, pc_in, valid_in, stall_in, flags_in,
    input  opcode_out, rd_out, rs1_out, rs2_out, imm_out, valid_out, ready_out,
           cond_br_taken, cond_br_target
`ifdef ID_ILLEGAL_TRAP_EN
    , input illegal_op
`endif
  );
  modport slave (
    input  instruction_in, pc_in, valid_in, stall_in, flags_in,
    output opcode_out, rd_out, rs1_out, rs2_out, imm_out, valid_out, ready_out,
           cond_br_taken, cond_br_target
`ifdef ID_ILLEGAL_TRAP_EN
    , output illegal_op
`endif
  );
endinterface

// File: rtl/instr_decode_cond_eval.sv
// cond_eval: combinational {N,Z,C,V} condition-code evaluator, shared with execute predication
module cond_eval
  import scc_isa_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [3:0] cond,
  output logic       take
);
  logic n, z, c, v;
  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];
  always_comb begin
    take = 1'b0;
    case (cond)
      COND_EQ: take = z;
      COND_NE: take = ~z;
      COND_CS: take = c;
      COND_CC: take = ~c;
      COND_MI: take = n;
      COND_PL: take = ~n;
      COND_VS: take = v;
      COND_VC: take = ~v;
      COND_HI: take = c & ~z;
      COND_LS: take = ~c | z;
      COND_GE: take = n ~^ v;
      COND_LT: take = n ^ v;
      COND_GT: take = ~z & (n ~^ v);
      COND_LE: take = z | (n ^ v);
      COND_AL: take = 1'b1;
      COND_NV: take = 1'b0;
      default: take = 1'b0;
    endcase
  end
endmodule

// File: rtl/instr_decode.sv
// instr_decode: ID stage splitting fetch words into registered fields and resolving conditional branches
// ID_ILLEGAL_TRAP_EN traps captured opcodes outside the legal ISA list
module instr_decode
  import scc_isa_pkg::*;
#(
  parameter int SQUASH_DEPTH = 2,
  parameter int IMM_W        = 16
) (
  input logic         clk,
  input logic         reset,
  instr_decode_if.slave bus
);
  localparam int CW = $clog2(SQUASH_DEPTH + 1);
  id_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0]    opcode_q, opcode_d;
  logic [2:0]    rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [31:0]   imm_q, imm_d, tgt_q, tgt_d, imm_ext;
  logic          valid_q, valid_d, br_q, br_d, take, legal, br_take;
  cond_eval u_cond (.flags(bus.flags_in), .cond(bus.instruction_in[24:21]), .take(take));
  assign imm_ext = {{(32-IMM_W){bus.instruction_in[IMM_W-1]}}, bus.instruction_in[IMM_W-1:0]};
  assign br_take = ~bus.stall_in & (state_q != ST_SQUASH) & bus.valid_in &
                   (bus.instruction_in[31:25] == OP_BCOND) & take;
`ifdef ID_ILLEGAL_TRAP_EN
  logic ill_q, ill_d;
  assign legal = is_legal_op(bus.instruction_in[31:25]);
  assign bus.illegal_op = ill_q;
`else
  assign legal = 1'b1;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    {opcode_d, rd_d, rs1_d, rs2_d, imm_d} = {opcode_q, rd_q, rs1_q, rs2_q, imm_q};
    valid_d = valid_q;
    br_d = 1'b0;
    tgt_d = br_take ? (bus.pc_in + imm_ext) & ~32'h3 : tgt_q;
`ifdef ID_ILLEGAL_TRAP_EN
    ill_d = 1'b0;
`endif
    if (!bus.stall_in)
      {opcode_d, rd_d, rs1_d, rs2_d, imm_d} = {bus.instruction_in[31:16], imm_ext};
    if (bus.stall_in) begin
      state_d = state_q == ST_SQUASH ? ST_SQUASH : ST_HOLD;
    end else if (state_q == ST_SQUASH) begin
      valid_d = 1'b0;
      cnt_d = bus.valid_in ? cnt_q - 1'b1 : cnt_q;
      state_d = cnt_d == '0 ? ST_RUN : ST_SQUASH;
    end else begin
      valid_d = bus.valid_in & legal;
      br_d = br_take;
      cnt_d = br_take ? CW'(SQUASH_DEPTH) : '0;
      state_d = br_take ? ST_SQUASH : ST_RUN;
`ifdef ID_ILLEGAL_TRAP_EN
      ill_d = bus.valid_in & ~legal;
`endif
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q <= '0;
      {opcode_q, rd_q, rs1_q, rs2_q, imm_q, tgt_q} <= '0;
      valid_q <= 1'b0;
      br_q <= 1'b0;
`ifdef ID_ILLEGAL_TRAP_EN
      ill_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      {opcode_q, rd_q, rs1_q, rs2_q, imm_q, tgt_q} <= {opcode_d, rd_d, rs1_d, rs2_d, imm_d, tgt_d};
      valid_q <= valid_d;
      br_q <= br_d;
`ifdef ID_ILLEGAL_TRAP_EN
      ill_q <= ill_d;
`endif
    end
  end
  assign bus.opcode_out = opcode_q;
  assign bus.rd_out = rd_q;
  assign bus.rs1_out = rs1_q;
  assign bus.rs2_out = rs2_q;
  assign bus.imm_out = imm_q;
  assign bus.valid_out = valid_q;
  assign bus.cond_br_taken = br_q;
  assign bus.cond_br_target = tgt_q;
  assign bus.ready_out = ~bus.stall_in;
endmodule

// File: tb/tb_instr_decode.sv
// tb_instr_decode: directed vectors against a word-level reference model of the ID stage
module tb_instr_decode;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  instr_decode_if bus();
  instr_decode dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
`ifdef ID_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  localparam logic [31:0] W = 32'h0A4B_FFFE;
  localparam logic [31:0] BEQ = 32'hC200_0010;
  logic [6:0]  m_op;
  logic [2:0]  m_rd, m_rs1, m_rs2;
  logic [31:0] m_imm, m_tgt;
  logic        m_valid, m_br, m_ill;
  int          m_skip;
  function automatic logic cond_ok(input logic [3:0] f, input logic [3:0] c);
    logic n, z, cy, v;
    logic [15:0] tbl;
    {n, z, cy, v} = f;
    tbl = {1'b0, 1'b1, z | (n != v), !z && (n == v), n != v, n == v, !cy || z, cy && !z,
           !v, v, !n, n, !cy, cy, !z, z};
    return tbl[c];
  endfunction
  function automatic logic legal(input logic [6:0] op);
    return !TRAP || op <= 7'h07 || op == 7'h20 || op == 7'h21 || (op >= 7'h60 && op <= 7'h62);
  endfunction
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      {m_op, m_rd, m_rs1, m_rs2, m_imm, m_tgt, m_valid, m_br, m_ill} <= '0;
      m_skip <= 0;
    end else begin
      m_br <= 1'b0;
      m_ill <= 1'b0;
      if (!bus.stall_in) begin
        {m_op, m_rd, m_rs1, m_rs2} <= bus.instruction_in[31:16];
        m_imm <= 32'($signed(bus.instruction_in[15:0]));
        if (m_skip > 0) begin
          m_valid <= 1'b0;
          if (bus.valid_in) m_skip <= m_skip - 1;
        end else begin
          m_valid <= bus.valid_in && legal(bus.instruction_in[31:25]);
          m_ill <= bus.valid_in && !legal(bus.instruction_in[31:25]);
          if (bus.valid_in && bus.instruction_in[31:25] == 7'b1100001 &&
              cond_ok(bus.flags_in, bus.instruction_in[24:21])) begin
            m_br <= 1'b1;
            m_tgt <= (bus.pc_in + 32'($signed(bus.instruction_in[15:0]))) & 32'hFFFF_FFFC;
            m_skip <= 2;
          end
        end
      end
    end
  end
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  task automatic model_check();
    cmp("valid_out", 32'(bus.valid_out), 32'(m_valid));
    cmp("cond_br_taken", 32'(bus.cond_br_taken), 32'(m_br));
    cmp("ready_out", 32'(bus.ready_out), 32'(!bus.stall_in));
    if (m_br) cmp("cond_br_target", bus.cond_br_target, m_tgt);
    if (m_valid) begin
      cmp("opcode_out", 32'(bus.opcode_out), 32'(m_op));
      cmp("rd_out", 32'(bus.rd_out), 32'(m_rd));
      cmp("rs1_out", 32'(bus.rs1_out), 32'(m_rs1));
      cmp("rs2_out", 32'(bus.rs2_out), 32'(m_rs2));
      cmp("imm_out", bus.imm_out, m_imm);
    end
`ifdef ID_ILLEGAL_TRAP_EN
    cmp("illegal_op", 32'(bus.illegal_op), 32'(m_ill));
`endif
  endtask
  task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic v,
                       input logic st, input logic [3:0] fl);
    bus.instruction_in = ins;
    bus.pc_in = pc;
    bus.valid_in = v;
    bus.stall_in = st;
    bus.flags_in = fl;
    @(posedge clk);
    @(negedge clk);
    model_check();
  endtask
  initial begin
    logic [31:0] ins;
    logic [3:0] pats [4] = '{4'b0000, 4'b0100, 4'b1001, 4'b0010};
    bus.instruction_in = W;
    bus.pc_in = '0;
    bus.valid_in = 1'b1;
    bus.stall_in = 1'b0;
    bus.flags_in = '0;
    @(negedge clk);
    @(negedge clk);
    cmp("rst_valid", 32'(bus.valid_out), 0);
    cmp("rst_pulse", 32'(bus.cond_br_taken), 0);
    cmp("rst_target", bus.cond_br_target, 0);
    cmp("rst_opcode", 32'(bus.opcode_out), 0);
    cmp("rst_imm", bus.imm_out, 0);
    reset = 1'b0;
    drive(W, 0, 1, 1, 0);
    cmp("rel_stall_valid", 32'(bus.valid_out), 0);
    drive(W, 0, 1, 0, 0);
    cmp("pipe_opcode", 32'(bus.opcode_out), 32'h05);
    cmp("pipe_rd", 32'(bus.rd_out), 1);
    cmp("pipe_rs1", 32'(bus.rs1_out), 1);
    cmp("pipe_rs2", 32'(bus.rs2_out), 3);
    cmp("pipe_imm", bus.imm_out, 32'hFFFF_FFFE);
    cmp("pipe_valid", 32'(bus.valid_out), 1);
    #2 reset = 1'b1;
    #1 cmp("mid_rst_valid", 32'(bus.valid_out), 0);
    cmp("mid_rst_opcode", 32'(bus.opcode_out), 0);
    #1 reset = 1'b0;
    @(negedge clk);
    cmp("post_rst_valid", 32'(bus.valid_out), 1);
    drive(BEQ, 32'h100, 1, 0, 4'b0100);
    cmp("beq_pulse", 32'(bus.cond_br_taken), 1);
    cmp("beq_target", bus.cond_br_target, 32'h110);
    cmp("beq_valid", 32'(bus.valid_out), 1);
    drive(W, 32'h104, 1, 0, 0);
    cmp("sq1_valid", 32'(bus.valid_out), 0);
    cmp("sq1_pulse", 32'(bus.cond_br_taken), 0);
    drive(BEQ, 32'h108, 1, 0, 4'b0100);
    cmp("sq_branch_pulse", 32'(bus.cond_br_taken), 0);
    cmp("sq2_valid", 32'(bus.valid_out), 0);
    drive(W, 32'h10C, 1, 0, 0);
    cmp("sq_done_valid", 32'(bus.valid_out), 1);
    drive(32'hC3C0_0020, 32'hFFFF_FFF0, 1, 0, 0);
    cmp("al_pulse", 32'(bus.cond_br_taken), 1);
    cmp("al_wrap_target", bus.cond_br_target, 32'h0000_0010);
    repeat (3) drive(W, 0, 1, 1, 0);
    cmp("stall_ready", 32'(bus.ready_out), 0);
    cmp("stall_valid_frozen", 32'(bus.valid_out), 1);
    cmp("stall_pulse", 32'(bus.cond_br_taken), 0);
    drive(W, 0, 0, 0, 0);
    drive(W, 0, 1, 0, 0);
    drive(W, 0, 1, 0, 0);
    cmp("stall_sq_valid", 32'(bus.valid_out), 0);
    drive(W, 0, 1, 0, 0);
    cmp("stall_sq_done", 32'(bus.valid_out), 1);
    drive(32'hC220_0010, 32'h300, 1, 0, 4'b0100);
    cmp("ne_pulse", 32'(bus.cond_br_taken), 0);
    cmp("ne_valid", 32'(bus.valid_out), 1);
    drive(W, 0, 1, 0, 0);
    cmp("ne_next_valid", 32'(bus.valid_out), 1);
    drive(BEQ, 32'h400, 1, 1, 4'b0100);
    cmp("stall_br_pulse", 32'(bus.cond_br_taken), 0);
    drive(BEQ, 32'h400, 1, 0, 4'b0000);
    cmp("reeval_nt_pulse", 32'(bus.cond_br_taken), 0);
    drive(BEQ, 32'h500, 1, 1, 4'b0100);
    drive(BEQ, 32'h500, 1, 0, 4'b0100);
    cmp("reeval_t_pulse", 32'(bus.cond_br_taken), 1);
    cmp("reeval_t_target", bus.cond_br_target, 32'h510);
    drive(W, 0, 1, 0, 0);
    drive(W, 0, 1, 0, 0);
    drive(32'hC000_0004, 32'h600, 1, 0, 4'b1111);
    cmp("b_pulse", 32'(bus.cond_br_taken), 0);
    drive(32'hC400_0000, 32'h604, 1, 0, 4'b1111);
    cmp("br_valid", 32'(bus.valid_out), 1);
    drive(W, 0, 0, 0, 0);
    cmp("bubble_valid", 32'(bus.valid_out), 0);
    drive({7'b1100001, 4'd12, 5'b0, 16'hFFF0}, 32'h800, 1, 0, 4'b1001);
    cmp("gt_pulse", 32'(bus.cond_br_taken), 1);
    cmp("gt_target", bus.cond_br_target, 32'h7F0);
    drive(W, 0, 1, 0, 0);
    drive(W, 0, 1, 0, 0);
    drive({7'b1100001, 4'd9, 5'b0, 16'h0008}, 32'h900, 1, 0, 4'b0010);
    cmp("ls_pulse", 32'(bus.cond_br_taken), 0);
    foreach (pats[p]) begin
      for (int c = 0; c < 16; c++) begin
        ins = {7'b1100001, 4'(c), 5'b0, 16'h0006};
        drive(ins, 32'h1000 + 32'(c), 1, 0, pats[p]);
        drive(W, 0, 1, 0, pats[p]);
        drive(W, 0, 1, 0, pats[p]);
      end
    end
`ifdef ID_ILLEGAL_TRAP_EN
    drive(32'hFE00_0000, 0, 1, 0, 0);
    cmp("illegal_set", 32'(bus.illegal_op), 1);
    cmp("illegal_valid", 32'(bus.valid_out), 0);
    drive(W, 0, 1, 0, 0);
    cmp("illegal_clear", 32'(bus.illegal_op), 0);
`endif
    drive(BEQ, 32'hA00, 1, 0, 4'b0100);
    cmp("presq_pulse", 32'(bus.cond_br_taken), 1);
    bus.instruction_in = W;
    #2 reset = 1'b1;
    #1 cmp("sq_rst_pulse", 32'(bus.cond_br_taken), 0);
    cmp("sq_rst_valid", 32'(bus.valid_out), 0);
    #1 reset = 1'b0;
    @(negedge clk);
    drive(W, 0, 1, 0, 0);
    cmp("sq_rst_no_squash", 32'(bus.valid_out), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
